// File: rtl/rotation_scheduler.sv
// rotation_scheduler
//   Launches and supervises steering moves for NUM_MOTORS angle_to_pwm instances.
//   Each motor has its own IDLE/PEND/ACTIVE/FAULT FSM. A round-robin arbiter grants
//   at most one PEND motor per cycle, and only while fewer than MAX_ACTIVE motors
//   are ACTIVE. Failed or timed-out moves are relaunched up to MAX_RETRY times, then
//   the motor latches FAULT until fault_clear.
//
// Ports
//   clock, reset_n  main clock, async active-low reset
//   cmd_valid       per-motor new-move pulse; cmd_angle holds 12-bit angles packed by motor
//   timeout_cycles  move time limit in clocks (0 disables the timeout)
//   fault_clear     per-motor FAULT clear pulse
//   angle_done      per-motor completion level (rising edge = done)
//   startup_fail    per-motor stall indication
//   target_angle    latched target per motor (held stable while ACTIVE)
//   angle_update    registered 1-cycle launch pulse
//   abort_angle     1-cycle abort pulse, high in the cycle the fail/timeout is detected
//   move_done       1-cycle completion pulse, high in the cycle the done edge is seen
//   busy / fault    motor in PEND|ACTIVE / motor in FAULT
module rotation_scheduler #(
   parameter int NUM_MOTORS = 4,
   parameter int MAX_ACTIVE = 2,
   parameter int MAX_RETRY  = 2,
   parameter int TIMEOUT_W  = 24
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [NUM_MOTORS-1:0]    cmd_valid,
   input  logic [12*NUM_MOTORS-1:0] cmd_angle,
   input  logic [TIMEOUT_W-1:0]     timeout_cycles,
   input  logic [NUM_MOTORS-1:0]    fault_clear,
   input  logic [NUM_MOTORS-1:0]    angle_done,
   input  logic [NUM_MOTORS-1:0]    startup_fail,
   output logic [12*NUM_MOTORS-1:0] target_angle,
   output logic [NUM_MOTORS-1:0]    angle_update,
   output logic [NUM_MOTORS-1:0]    abort_angle,
   output logic [NUM_MOTORS-1:0]    busy,
   output logic [NUM_MOTORS-1:0]    fault,
   output logic [NUM_MOTORS-1:0]    move_done
);

   localparam int         PW          = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
   localparam logic [1:0] MAX_RETRY_L = 2'(MAX_RETRY);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACTIVE, S_FAULT} state_t;

   logic [NUM_MOTORS-1:0] is_act, is_pend, grant;
   logic [PW-1:0]         rr_q, grant_idx, arb_idx;
   logic                  found;
   int                    active_cnt;

   // Arbiter: slots are counted from registered state, so a motor leaving ACTIVE
   // this cycle still occupies its slot until the next cycle.
   always_comb begin
      active_cnt = 0;
      grant      = '0;
      grant_idx  = rr_q;
      arb_idx    = rr_q;
      found      = 1'b0;
      for (int k = 0; k < NUM_MOTORS; k++)
         if (is_act[k]) active_cnt = active_cnt + 1;
      if (active_cnt < MAX_ACTIVE) begin
         for (int k = 0; k < NUM_MOTORS; k++) begin
            arb_idx = PW'((int'(rr_q) + k) % NUM_MOTORS);
            if (!found && is_pend[arb_idx]) begin
               grant[arb_idx] = 1'b1;
               grant_idx      = arb_idx;
               found          = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)   rr_q <= '0;
      else if (found) rr_q <= PW'((int'(grant_idx) + 1) % NUM_MOTORS);
   end

   for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_motor
      state_t               st_q, st_d;
      logic [11:0]          tgt_q, tgt_d, shd_q, shd_d, cmd_i, shd_eff;
      logic                 shv_q, shv_d, shv_eff, done_prev_q, rise, tmo;
      logic                 upd_q, upd_d, abort_c, done_c;
      logic [1:0]           rty_q, rty_d;
      logic [TIMEOUT_W-1:0] tmr_q, tmr_d;

      assign cmd_i   = cmd_angle[12*i +: 12];
      assign rise    = angle_done[i] & ~done_prev_q;
      assign tmo     = (timeout_cycles != '0) && (tmr_q == timeout_cycles);
      // A command arriving in the completion cycle is the newest, so it wins.
      assign shd_eff = cmd_valid[i] ? cmd_i : shd_q;
      assign shv_eff = shv_q | cmd_valid[i];

      assign is_act[i]                 = (st_q == S_ACTIVE);
      assign is_pend[i]                = (st_q == S_PEND);
      assign busy[i]                   = is_act[i] | is_pend[i];
      assign fault[i]                  = (st_q == S_FAULT);
      assign target_angle[12*i +: 12]  = tgt_q;
      assign angle_update[i]           = upd_q;
      assign abort_angle[i]            = abort_c;
      assign move_done[i]              = done_c;

      always_comb begin
         st_d    = st_q;
         tgt_d   = tgt_q;
         shd_d   = shd_q;
         shv_d   = shv_q;
         rty_d   = rty_q;
         tmr_d   = tmr_q;
         upd_d   = 1'b0;
         abort_c = 1'b0;
         done_c  = 1'b0;
         case (st_q)
            S_IDLE: if (cmd_valid[i]) begin
               tgt_d = cmd_i;
               rty_d = '0;
               st_d  = S_PEND;
            end
            S_PEND: begin
               if (cmd_valid[i]) tgt_d = cmd_i;
               if (grant[i]) begin
                  st_d  = S_ACTIVE;
                  tmr_d = '0;
                  upd_d = 1'b1;
               end
            end
            S_ACTIVE: begin
               if (tmr_q != '1) tmr_d = tmr_q + 1'b1;
               // Target stays frozen mid-move; new commands wait in the shadow.
               if (cmd_valid[i]) begin
                  shd_d = cmd_i;
                  shv_d = 1'b1;
               end
               if (rise) begin
                  done_c = 1'b1;
                  if (shv_eff) begin
                     tgt_d = shd_eff;
                     shv_d = 1'b0;
                     rty_d = '0;
                     st_d  = S_PEND;
                  end else begin
                     st_d  = S_IDLE;
                  end
               end else if (startup_fail[i] || tmo) begin
                  abort_c = 1'b1;
                  if (rty_q < MAX_RETRY_L) begin
                     rty_d = rty_q + 2'd1;
                     st_d  = S_PEND;
                  end else begin
                     st_d  = S_FAULT;
                  end
               end
            end
            S_FAULT: if (fault_clear[i]) begin
               rty_d = '0;
               shv_d = 1'b0;
               if (cmd_valid[i]) begin
                  tgt_d = cmd_i;
                  st_d  = S_PEND;
               end else begin
                  st_d  = S_IDLE;
               end
            end
            default: st_d = S_IDLE;
         endcase
      end

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            st_q        <= S_IDLE;
            tgt_q       <= '0;
            shd_q       <= '0;
            shv_q       <= 1'b0;
            rty_q       <= '0;
            tmr_q       <= '0;
            upd_q       <= 1'b0;
            done_prev_q <= 1'b0;
         end else begin
            st_q        <= st_d;
            tgt_q       <= tgt_d;
            shd_q       <= shd_d;
            shv_q       <= shv_d;
            rty_q       <= rty_d;
            tmr_q       <= tmr_d;
            upd_q       <= upd_d;
            done_prev_q <= angle_done[i];
         end
      end
   end

endmodule

// File: tb/tb_rotation_scheduler.sv
module tb_rotation_scheduler;
   localparam int NM = 4;
   localparam int K_UPD = 0, K_ABT = 1, K_DONE = 2;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic [NM-1:0]     cmd_valid = '0;
   logic [12*NM-1:0]  cmd_angle = '0;
   logic [23:0]       timeout_cycles = '0;
   logic [NM-1:0]     fault_clear = '0;
   logic [NM-1:0]     angle_done = '0;
   logic [NM-1:0]     startup_fail = '0;
   logic [12*NM-1:0]  target_angle;
   logic [NM-1:0]     angle_update, abort_angle, busy, fault, move_done;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {int kind; int motor;} ev_t;
   ev_t sb[$];

   rotation_scheduler #(.NUM_MOTORS(NM), .MAX_ACTIVE(2), .MAX_RETRY(2), .TIMEOUT_W(24)) dut (
      .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_angle(cmd_angle),
      .timeout_cycles(timeout_cycles), .fault_clear(fault_clear), .angle_done(angle_done),
      .startup_fail(startup_fail), .target_angle(target_angle), .angle_update(angle_update),
      .abort_angle(abort_angle), .busy(busy), .fault(fault), .move_done(move_done));

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int k, input int m);
      ev_t e;
      e.kind = k;
      e.motor = m;
      sb.push_back(e);
   endtask

   task automatic cmd(input int m, input logic [11:0] a);
      cmd_valid[m] = 1'b1;
      cmd_angle[12*m +: 12] = a;
      tick();
      cmd_valid = '0;
   endtask

   // Scoreboard: every output pulse must match the next expected event in order.
   always @(negedge clock) begin
      ev_t e;
      logic hit;
      for (int m = 0; m < NM; m++) begin
         for (int k = 0; k < 3; k++) begin
            hit = (k == K_UPD) ? angle_update[m] : (k == K_ABT) ? abort_angle[m] : move_done[m];
            if (hit) begin
               total_cnt++;
               if (sb.size() == 0) begin
                  $display("FAIL sb_event got kind=%0d motor=%0d want none (t=%0t)", k, m, $time);
               end else begin
                  e = sb.pop_front();
                  if (e.kind !== k || e.motor !== m)
                     $display("FAIL sb_event got kind=%0d motor=%0d want kind=%0d motor=%0d (t=%0t)",
                              k, m, e.kind, e.motor, $time);
                  else pass_cnt++;
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      total_cnt++;
      if ({busy, fault, angle_update, abort_angle, move_done} !== '0 || target_angle !== '0)
         $display("FAIL reset_outputs got busy=%b fault=%b upd=%b tgt=%h want all 0", busy, fault, angle_update, target_angle);
      else pass_cnt++;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_arbitration();
      push(K_UPD, 0); push(K_UPD, 1);
      cmd_valid = 4'hF;
      cmd_angle = {12'd400, 12'd300, 12'd200, 12'd100};
      tick();
      cmd_valid = '0;
      repeat (6) tick();
      total_cnt++;
      if (busy !== 4'hF) $display("FAIL arb_busy got %b want 1111", busy);
      else pass_cnt++;
      total_cnt++;
      if (target_angle !== {12'd400, 12'd300, 12'd200, 12'd100})
         $display("FAIL arb_target got %h want %h", target_angle, {12'd400, 12'd300, 12'd200, 12'd100});
      else pass_cnt++;
      push(K_DONE, 0); push(K_UPD, 2);
      angle_done = 4'b0001; tick(); angle_done = '0;
      repeat (4) tick();
      push(K_DONE, 1); push(K_UPD, 3);
      angle_done = 4'b0010; tick(); angle_done = '0;
      repeat (4) tick();
      push(K_DONE, 2); push(K_DONE, 3);
      angle_done = 4'b1100; tick(); angle_done = '0;
      tick();
      total_cnt++;
      if (busy !== 4'h0 || sb.size() != 0) $display("FAIL arb_end got busy=%b pending=%0d want 0000/0", busy, sb.size());
      else pass_cnt++;
   endtask

   task automatic test_single_move();
      int bad;
      bad = 0;
      push(K_UPD, 0);
      cmd(0, 12'd1024);
      total_cnt++;
      if (busy[0] !== 1'b1 || angle_update[0] !== 1'b0)
         $display("FAIL lat_pend got busy=%b upd=%b want 1/0", busy[0], angle_update[0]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (angle_update[0] !== 1'b1) $display("FAIL lat_launch got upd=%b want 1", angle_update[0]);
      else pass_cnt++;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (target_angle[11:0] !== 12'd1024 || busy[0] !== 1'b1) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL move_target got %0d bad cycles want 0", bad);
      else pass_cnt++;
      push(K_DONE, 0);
      angle_done[0] = 1'b1;
      #1;
      total_cnt++;
      if (move_done[0] !== 1'b1) $display("FAIL move_done got %b want 1", move_done[0]);
      else pass_cnt++;
      tick();
      angle_done = '0;
      total_cnt++;
      if (busy[0] !== 1'b0 || target_angle[11:0] !== 12'd1024)
         $display("FAIL move_end got busy=%b tgt=%0d want 0/1024", busy[0], target_angle[11:0]);
      else pass_cnt++;
   endtask

   task automatic test_fault_retry();
      startup_fail[1] = 1'b1;
      repeat (3) begin push(K_UPD, 1); push(K_ABT, 1); end
      cmd(1, 12'd77);
      repeat (10) tick();
      total_cnt++;
      if (fault !== 4'b0010 || busy[1] !== 1'b0) $display("FAIL fault_set got fault=%b busy=%b want 0010/0", fault, busy[1]);
      else pass_cnt++;
      cmd(1, 12'd999);
      tick();
      total_cnt++;
      if (fault[1] !== 1'b1 || busy[1] !== 1'b0 || target_angle[23:12] !== 12'd77)
         $display("FAIL fault_ignore got fault=%b busy=%b tgt=%0d want 1/0/77", fault[1], busy[1], target_angle[23:12]);
      else pass_cnt++;
      startup_fail = '0;
      fault_clear[1] = 1'b1;
      tick();
      fault_clear = '0;
      total_cnt++;
      if (fault !== 4'b0000 || busy[1] !== 1'b0) $display("FAIL fault_clear got fault=%b busy=%b want 0000/0", fault, busy[1]);
      else pass_cnt++;
      total_cnt++;
      if (sb.size() != 0) $display("FAIL fault_events got pending=%0d want 0", sb.size());
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int n;
      timeout_cycles = 24'd100;
      push(K_UPD, 2); push(K_ABT, 2); push(K_UPD, 2);
      cmd(2, 12'd333);
      n = 0;
      while (angle_update[2] !== 1'b1 && n < 10) begin tick(); n++; end
      total_cnt++;
      if (angle_update[2] !== 1'b1) $display("FAIL tmo_launch got no launch in %0d cycles want launch", n);
      else pass_cnt++;
      n = 0;
      while (abort_angle[2] !== 1'b1 && n < 200) begin tick(); n++; end
      total_cnt++;
      if (n != 100) $display("FAIL tmo_delay got %0d cycles want 100", n);
      else pass_cnt++;
      tick();
      timeout_cycles = '0;
      repeat (1500) tick();
      total_cnt++;
      if (busy[2] !== 1'b1 || fault[2] !== 1'b0) $display("FAIL tmo_disabled got busy=%b fault=%b want 1/0", busy[2], fault[2]);
      else pass_cnt++;
      push(K_DONE, 2);
      angle_done[2] = 1'b1; tick(); angle_done = '0;
      tick();
      total_cnt++;
      if (busy[2] !== 1'b0 || sb.size() != 0) $display("FAIL tmo_end got busy=%b pending=%0d want 0/0", busy[2], sb.size());
      else pass_cnt++;
   endtask

   task automatic test_shadow();
      int bad;
      bad = 0;
      push(K_UPD, 3);
      cmd(3, 12'd500);
      repeat (3) tick();
      cmd(3, 12'd900);
      for (int c = 0; c < 5; c++) begin
         if (target_angle[47:36] !== 12'd500 || busy[3] !== 1'b1) bad++;
         tick();
      end
      total_cnt++;
      if (bad != 0) $display("FAIL shadow_hold got %0d bad cycles want 0", bad);
      else pass_cnt++;
      push(K_DONE, 3); push(K_UPD, 3);
      angle_done[3] = 1'b1; tick(); angle_done = '0;
      tick();
      total_cnt++;
      if (target_angle[47:36] !== 12'd900 || busy[3] !== 1'b1)
         $display("FAIL shadow_relaunch got tgt=%0d busy=%b want 900/1", target_angle[47:36], busy[3]);
      else pass_cnt++;
      tick();
      push(K_DONE, 3);
      angle_done[3] = 1'b1; tick(); angle_done = '0;
      tick();
      total_cnt++;
      if (busy[3] !== 1'b0 || sb.size() != 0) $display("FAIL shadow_end got busy=%b pending=%0d want 0/0", busy[3], sb.size());
      else pass_cnt++;
   endtask

   task automatic test_done_vs_fail();
      push(K_UPD, 0);
      cmd(0, 12'd55);
      repeat (2) tick();
      push(K_DONE, 0);
      angle_done[0] = 1'b1;
      startup_fail[0] = 1'b1;
      #1;
      total_cnt++;
      if (move_done[0] !== 1'b1 || abort_angle[0] !== 1'b0)
         $display("FAIL done_wins got done=%b abort=%b want 1/0", move_done[0], abort_angle[0]);
      else pass_cnt++;
      tick();
      angle_done = '0;
      startup_fail = '0;
      total_cnt++;
      if (busy[0] !== 1'b0 || fault[0] !== 1'b0) $display("FAIL done_wins_state got busy=%b fault=%b want 0/0", busy[0], fault[0]);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      push(K_UPD, 1);
      cmd(1, 12'd1234);
      repeat (4) tick();
      total_cnt++;
      if (busy[1] !== 1'b1) $display("FAIL areset_pre got busy=%b want 1", busy[1]);
      else pass_cnt++;
      #2 reset_n = 1'b0;
      #1;
      total_cnt++;
      if ({busy, fault, angle_update, abort_angle, move_done} !== '0 || target_angle !== '0)
         $display("FAIL areset_outputs got busy=%b tgt=%h want 0/0", busy, target_angle);
      else pass_cnt++;
      tick();
      reset_n = 1'b1;
      repeat (3) tick();
      total_cnt++;
      if (busy !== 4'h0 || sb.size() != 0) $display("FAIL areset_post got busy=%b pending=%0d want 0000/0", busy, sb.size());
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_single_move();
      test_fault_retry();
      test_timeout();
      test_shadow();
      test_done_vs_fail();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
